// File: rtl/gpio_mmio_ctrl.sv
// Memory-mapped GPIO peripheral: synchronised and debounced switch inputs
// with sticky change flags, a writable LED register and a maskable level
// interrupt, exposed as a 4-word window on the 16-bit data-memory bus.
module gpio_mmio_ctrl #(
  parameter int SW_W        = 10,
  parameter int LED_W       = 10,
  parameter int DBNC_CYCLES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [SW_W-1:0]  SW,
  output logic [LED_W-1:0] LEDR,
  input  logic [1:0]       addr,
  input  logic             wr_en,
  input  logic             rd_en,
  input  logic [15:0]      wdata,
  output logic [15:0]      rdata,
  output logic             rd_valid,
  output logic             irq
);

  localparam int CNT_W = (DBNC_CYCLES > 1) ? $clog2(DBNC_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DBNC_CYCLES - 1);

  localparam logic [1:0] ADDR_SW_DATA    = 2'd0;
  localparam logic [1:0] ADDR_LED_DATA   = 2'd1;
  localparam logic [1:0] ADDR_SW_CHANGED = 2'd2;
  localparam logic [1:0] ADDR_IRQ_EN     = 2'd3;

  logic [SW_W-1:0]             sync1_reg;
  logic [SW_W-1:0]             sync2_reg;
  logic [SW_W-1:0]             db_reg;
  logic [SW_W-1:0]             db_next;
  logic [SW_W-1:0][CNT_W-1:0]  cnt_reg;
  logic [SW_W-1:0][CNT_W-1:0]  cnt_next;
  logic [SW_W-1:0]             chg_evt;

  logic [LED_W-1:0] led_reg;
  logic [LED_W-1:0] led_next;
  logic [SW_W-1:0]  sw_changed_reg;
  logic [SW_W-1:0]  sw_changed_next;
  logic [SW_W-1:0]  irq_en_reg;
  logic [SW_W-1:0]  irq_en_next;
  logic [SW_W-1:0]  clr_mask;
  logic [15:0]      rdata_reg;
  logic [15:0]      rd_mux;
  logic             rd_valid_reg;

  logic wr_led;
  logic wr_chg;
  logic wr_irq_en;

  // Upper write-data bits are architecturally dropped for narrow registers.
  logic unused_wdata;
  assign unused_wdata = ^wdata;

  // Per-bit debounce: a bit only flips after the synchronised value has
  // disagreed with it for DBNC_CYCLES consecutive cycles; the flip itself
  // is the change event.
  genvar gi;
  generate
    for (gi = 0; gi < SW_W; gi = gi + 1) begin : g_dbnc
      logic same;
      logic at_max;
      assign same         = (sync2_reg[gi] == db_reg[gi]);
      assign at_max       = (cnt_reg[gi] == CNT_MAX);
      assign chg_evt[gi]  = ~same & at_max;
      assign db_next[gi]  = chg_evt[gi] ? sync2_reg[gi] : db_reg[gi];
      assign cnt_next[gi] = (same | at_max) ? '0 : cnt_reg[gi] + CNT_W'(1);
    end
  endgenerate

  assign wr_led    = wr_en && (addr == ADDR_LED_DATA);
  assign wr_chg    = wr_en && (addr == ADDR_SW_CHANGED);
  assign wr_irq_en = wr_en && (addr == ADDR_IRQ_EN);

  assign clr_mask        = wr_chg ? wdata[SW_W-1:0] : '0;
  // A change event on the same edge as a clear keeps the flag set.
  assign sw_changed_next = (sw_changed_reg & ~clr_mask) | chg_evt;
  assign led_next        = wr_led ? wdata[LED_W-1:0] : led_reg;
  assign irq_en_next     = wr_irq_en ? wdata[SW_W-1:0] : irq_en_reg;

  // Read mux over current register values, so a same-cycle write is not seen.
  always_comb begin
    rd_mux = '0;
    case (addr)
      ADDR_SW_DATA:    rd_mux[SW_W-1:0]  = db_reg;
      ADDR_LED_DATA:   rd_mux[LED_W-1:0] = led_reg;
      ADDR_SW_CHANGED: rd_mux[SW_W-1:0]  = sw_changed_reg;
      ADDR_IRQ_EN:     rd_mux[SW_W-1:0]  = irq_en_reg;
      default:         rd_mux            = '0;
    endcase
  end

  // All state: synchroniser, debounce, registers and registered read port.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_reg      <= '0;
      sync2_reg      <= '0;
      db_reg         <= '0;
      cnt_reg        <= '0;
      led_reg        <= '0;
      sw_changed_reg <= '0;
      irq_en_reg     <= '0;
      rdata_reg      <= '0;
      rd_valid_reg   <= 1'b0;
    end else begin
      sync1_reg      <= SW;
      sync2_reg      <= sync1_reg;
      db_reg         <= db_next;
      cnt_reg        <= cnt_next;
      led_reg        <= led_next;
      sw_changed_reg <= sw_changed_next;
      irq_en_reg     <= irq_en_next;
      if (rd_en) begin
        rdata_reg <= rd_mux;
      end
      rd_valid_reg   <= rd_en;
    end
  end

  assign LEDR     = led_reg;
  assign rdata    = rdata_reg;
  assign rd_valid = rd_valid_reg;
  assign irq      = |(sw_changed_reg & irq_en_reg);

endmodule

// File: doc/gpio_mmio_ctrl.md
Name: gpio_mmio_ctrl

Overview:
- Parametrised memory-mapped GPIO peripheral for the pipelined processor's board top. Replaces direct wiring of switches (SW) and LEDs (LEDR).
- Switch inputs are synchronised, debounced per bit and change-tracked.
- The LED output register is processor-writable.
- A maskable interrupt fires on debounced switch changes.
- Sits on the processor's 16-bit data-memory bus as a 4-word I/O window.

Parameters:
- SW_W, 10, number of switch inputs (1..16)
- LED_W, 10, number of LED outputs (1..16)
- DBNC_CYCLES, 4, consecutive stable synchronised cycles required before a debounced bit changes (>=1)

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous active-low reset
- SW  in  SW_W  raw asynchronous switch pins
- LEDR  out  LED_W  LED drive; equals the LED_DATA register
- addr  in  2  word address within the window
- wr_en  in  1  bus write strobe
- rd_en  in  1  bus read strobe
- wdata  in  16  write data
- rdata  out  16  registered read data
- rd_valid  out  1  high exactly one cycle after an accepted rd_en
- irq  out  1  interrupt request, level

Behaviour:
- Reset (rst_n low at a clk edge):
  - sync flops, debounced value, per-bit counters, LED_DATA, SW_CHANGED, IRQ_EN, rdata and rd_valid all go to 0.
  - LEDR=0 and irq=0 on the next cycle.
  - Reset mid-debounce discards the count.
- Register map (addr):
  - 0 SW_DATA: RO, debounced switches in [SW_W-1:0]. Writes are ignored.
  - 1 LED_DATA: RW, [LED_W-1:0]. Write upper bits are dropped; readback upper bits are 0.
  - 2 SW_CHANGED: sticky per bit, write-1-to-clear.
  - 3 IRQ_EN: RW, [SW_W-1:0] per-bit interrupt mask.
  - All unused high bits read 0.
- Synchroniser: two flops per bit (sync1 <= SW, sync2 <= sync1).
- Debounce, per bit:
  - If sync2 == db: cnt <= 0.
  - Else if cnt == DBNC_CYCLES-1: db <= sync2, cnt <= 0, and the changed event fires.
  - Else: cnt <= cnt+1.
  - Counter width is clog2(DBNC_CYCLES), minimum 1.
  - A glitch shorter than DBNC_CYCLES sampled cycles never reaches db.
- Latency: a pin value sampled into sync1 at edge k is visible in db (SW_DATA) after edge k+1+DBNC_CYCLES (k+5 with defaults). The SW_CHANGED bit sets on that same edge.
- SW_CHANGED set/clear:
  - Changed event sets the bit.
  - A write to addr 2 clears the bits where wdata=1.
  - Same-cycle set and clear on the same bit: set wins.
- A switch held high through reset debounces to 1 after reset and sets its SW_CHANGED bit. Firmware clears it at init.
- irq = |(SW_CHANGED & IRQ_EN), driven from registers with no further delay. It stays high until the bits are cleared or masked.
- Reads:
  - rd_en at edge n: rdata and rd_valid=1 are presented after edge n; rd_valid drops after n+1 unless rd_en is repeated.
  - rdata holds its last value when there is no read.
  - Back-to-back reads are allowed every cycle.
- Read and write on the same cycle, same address: the read returns the pre-write value. The write takes effect on that edge.
- LED write: LEDR updates after the write edge, with 1-cycle latency from wr_en.

Test Plan:
- Reset, then SW=10'h155 held 10 cycles; read addr 0:
  - rdata=16'h0155, rd_valid one cycle.
  - SW_CHANGED=16'h0155.
  - irq=0 (IRQ_EN=0).
- Write addr 1 wdata=16'hFAFF:
  - LEDR=10'h2FF the next cycle.
  - Read addr 1 returns 16'h02FF.
- SW bit0 pulses high for 3 cycles (DBNC_CYCLES=4) from a stable 0:
  - SW_DATA bit0 stays 0 and SW_CHANGED bit0 stays 0.
  - Repeat with a 4-cycle-stable pulse: bit0 becomes 1 exactly 5 edges after the sync1 sample.
- IRQ_EN=16'h0001, then SW 10'h000->10'h001:
  - irq rises on the debounce edge.
  - Write addr 2 wdata=16'h0001 clears it.
  - If a new bit0 change event coincides with that clear, SW_CHANGED bit0 stays 1 and irq stays high.
- Mid-debounce (cnt=2), assert rst_n=0 for 1 cycle with SW=10'h3FF:
  - All outputs read 0 after reset.
  - SW_DATA reaches 16'h03FF after 2+DBNC_CYCLES cycles.
- Same-cycle rd_en+wr_en to addr 1 (old 16'h0011, new 16'h0022):
  - rdata=16'h0011.
  - A following read returns 16'h0022.
